hilo_muldiv_unit: RTL

Multi-cycle multiply/divide unit with the architectural HI/LO register pair for the pipelined MIPS-32 core. It sits in EX beside the ALU and executes the HI/LO-class operation codes emitted by `Control_unit`: mult, multu, div, divu, mfhi, mflo, mthi and mtlo. Mult and div run iteratively for a fixed 33 cycles. The unit returns a stall request to the hazard logic whenever an HI/LO-class instruction arrives while an iteration is in progress.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/muldiv_iter.sv | 67 ++++++
 rtl/hilo_muldiv_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-32 decode constants and the HI/LO multiply/divide state encoding.
// Control_unit uses the same operation codes, so keep them in sync.
package mips_pkg;

    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_MFHI  = 5'b10011;
    localparam logic [4:0] OP_MFLO  = 5'b10100;
    localparam logic [4:0] OP_MTHI  = 5'b10101;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    localparam int         ITER_CNT_W = 5;
    localparam logic [4:0] ITER_LAST  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    function automatic logic is_hilo_op(input logic [4:0] op);
        return (op == OP_DIV)  || (op == OP_DIVU) || (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// One step per cycle while i_step is high; the caller sequences 32 steps and owns the sign handling.
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic           i_is_div,
    input  logic           i_step,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_prod,
    output logic [W-1:0]   o_quot,
    output logic [W-1:0]   o_rem
);

    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_shift;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_divisor;
    logic           r_is_div;

    logic [W:0]     w_rem_sh;
    logic [W+1:0]   w_diff;
    logic           w_fits;

    // r_shift holds the multiplier bits for mul, and the dividend turning into the quotient for div
    assign w_rem_sh = {r_rem, r_shift[W-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_divisor};
    assign w_fits   = !w_diff[W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_shift   <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_is_div  <= 1'b0;
        end else if (i_load) begin
            r_is_div  <= i_is_div;
            r_acc     <= '0;
            r_mcand   <= {{W{1'b0}}, i_a};
            r_shift   <= i_is_div ? i_a : i_b;
            r_rem     <= '0;
            r_divisor <= i_b;
        end else if (i_step) begin
            if (r_is_div) begin
                r_rem   <= w_fits ? w_diff[W-1:0] : w_rem_sh[W-1:0];
                r_shift <= {r_shift[W-2:0], w_fits};
            end else begin
                if (r_shift[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand <= r_mcand << 1;
                r_shift <= r_shift >> 1;
            end
        end
    end

    assign o_prod = r_acc;
    assign o_quot = r_shift;
    assign o_rem  = r_rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with a 33-cycle iterative mult/div (32 steps + sign fix-up), plus mfhi/mflo/mthi/mtlo.
// HI/LO-class ops arriving while busy raise stall; nothing is queued, other ops pass untouched.
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [4:0]        operation,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);

    md_state_t               r_state;
    md_state_t               w_next_state;
    logic [ITER_CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]       r_hi;
    logic [DATA_W-1:0]       r_lo;
    logic                    r_signed;
    logic                    r_is_div;
    logic                    r_neg_a;
    logic                    r_neg_b;
    logic                    r_div_zero;

    logic                    w_hilo_op;
    logic                    w_accept;
    logic                    w_start_mul;
    logic                    w_start_div;
    logic                    w_signed_op;
    logic                    w_step;
    logic [DATA_W-1:0]       w_mag_a;
    logic [DATA_W-1:0]       w_mag_b;
    logic [2*DATA_W-1:0]     w_prod;
    logic [DATA_W-1:0]       w_quot;
    logic [DATA_W-1:0]       w_rem;
    logic                    w_res_neg;
    logic [2*DATA_W-1:0]     w_prod_fix;
    logic [DATA_W-1:0]       w_quot_fix;
    logic [DATA_W-1:0]       w_rem_fix;

    assign w_hilo_op   = is_hilo_op(operation);
    assign stall       = op_valid & w_hilo_op & busy;
    assign w_accept    = op_valid & w_hilo_op & !stall;
    assign w_start_mul = w_accept & ((operation == OP_MULT) | (operation == OP_MULTU));
    assign w_start_div = w_accept & ((operation == OP_DIV)  | (operation == OP_DIVU));
    assign w_signed_op = (operation == OP_MULT) | (operation == OP_DIV);

    assign w_mag_a = (w_signed_op & rs_val[DATA_W-1]) ? -rs_val : rs_val;
    assign w_mag_b = (w_signed_op & rt_val[DATA_W-1]) ? -rt_val : rt_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_mul) begin
                    w_next_state = ST_MUL;
                end else if (w_start_div) begin
                    w_next_state = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == ITER_LAST) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        w_step = 1'b0;
        case (r_state)
            ST_MUL, ST_DIV: begin
                busy   = 1'b1;
                w_step = 1'b1;
            end
            ST_FIX: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed   <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_start_mul | w_start_div) begin
            r_signed   <= w_signed_op;
            r_is_div   <= w_start_div;
            r_neg_a    <= w_signed_op & rs_val[DATA_W-1];
            r_neg_b    <= w_signed_op & rt_val[DATA_W-1];
            r_div_zero <= (rt_val == '0);
        end
    end

    muldiv_iter #(
        .W (DATA_W)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_start_mul | w_start_div),
        .i_is_div (w_start_div),
        .i_step   (w_step),
        .i_a      (w_mag_a),
        .i_b      (w_mag_b),
        .o_prod   (w_prod),
        .o_quot   (w_quot),
        .o_rem    (w_rem)
    );

    // Divide by zero keeps the all-ones quotient unsigned so LO stays 0xFFFFFFFF for any dividend sign
    assign w_res_neg  = r_signed & (r_neg_a ^ r_neg_b);
    assign w_prod_fix = w_res_neg ? -w_prod : w_prod;
    assign w_quot_fix = (w_res_neg & !r_div_zero) ? -w_quot : w_quot;
    assign w_rem_fix  = r_neg_a ? -w_rem : w_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == ST_FIX) begin
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quot_fix;
            end else begin
                r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                r_lo <= w_prod_fix[DATA_W-1:0];
            end
        end else if (w_accept && operation == OP_MTHI) begin
            r_hi <= rs_val;
        end else if (w_accept && operation == OP_MTLO) begin
            r_lo <= rs_val;
        end
    end

    always_comb begin
        rd_data = '0;
        if (op_valid && operation == OP_MFHI) begin
            rd_data = r_hi;
        end else if (op_valid && operation == OP_MFLO) begin
            rd_data = r_lo;
        end
    end

endmodule
